// File: rtl/antenna_select_ctrl.sv
// rtl/antenna_select_ctrl.sv - per-radio antenna stepping with debounced buttons and break-before-make relays
module antenna_select_ctrl #(
  parameter int N_ANT           = 6,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SWITCH_DELAY    = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_a_n,
  input  logic             btn_b_n,
  output logic [2:0]       sel_a,
  output logic [2:0]       sel_b,
  output logic             collision_a,
  output logic             collision_b,
  output logic [N_ANT-1:0] relay_a,
  output logic [N_ANT-1:0] relay_b
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DWW = $clog2(SWITCH_DELAY + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BREAK   = 2'd1,
    ST_COLLIDE = 2'd2
  } state_t;

  // Index 0 is radio A, index 1 is radio B.
  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]       db_q, db_d, press_q, press_d;
  logic [DBW-1:0]   db_cnt_q [2];
  logic [DBW-1:0]   db_cnt_d [2];
  state_t           state_q  [2];
  state_t           state_d  [2];
  logic [DWW-1:0]   dwell_q  [2];
  logic [DWW-1:0]   dwell_d  [2];
  logic [2:0]       sel_q    [2];
  logic [2:0]       sel_d    [2];
  logic [N_ANT-1:0] relay_q  [2];
  logic [N_ANT-1:0] relay_d  [2];
  logic [1:0]       coll_q, coll_d;
  logic             blocked;

  function automatic logic [2:0] step_sel(input logic [2:0] s);
    return (s == 3'(N_ANT - 1)) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [N_ANT-1:0] one_hot(input logic [2:0] s);
    logic [N_ANT-1:0] v;
    v = {{(N_ANT-1){1'b0}}, 1'b1};
    return v << s;
  endfunction

  always_comb begin
    sync1_d = {btn_b_n, btn_a_n};
    sync2_d = sync1_q;
    db_d    = db_q;
    press_d = 2'b00;
    for (int r = 0; r < 2; r++) begin
      db_cnt_d[r] = '0;
      if (sync2_q[r] != db_q[r]) begin
        if (db_cnt_q[r] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[r] = sync2_q[r];
        end else begin
          db_cnt_d[r] = db_cnt_q[r] + DBW'(1);
        end
      end
      press_d[r] = db_q[r] & ~db_d[r];
    end
  end

  // Radio B sees radio A's next state so a simultaneous finish resolves in A's favour.
  always_comb begin
    blocked = 1'b0;
    coll_d  = 2'b00;
    for (int r = 0; r < 2; r++) begin
      state_d[r] = state_q[r];
      dwell_d[r] = dwell_q[r];
      sel_d[r]   = sel_q[r];
      if (r == 0) begin
        blocked = (state_q[1] == ST_IDLE) && (sel_q[1] == sel_q[0]);
      end else begin
        blocked = (state_d[0] == ST_IDLE) && (sel_d[0] == sel_q[1]);
      end
      case (state_q[r])
        ST_IDLE: begin
          if (press_q[r]) begin
            sel_d[r]   = step_sel(sel_q[r]);
            state_d[r] = ST_BREAK;
            dwell_d[r] = '0;
          end
        end
        ST_BREAK: begin
          if (press_q[r]) begin
            sel_d[r]   = step_sel(sel_q[r]);
            dwell_d[r] = '0;
          end else if (dwell_q[r] == DWW'(SWITCH_DELAY - 1)) begin
            dwell_d[r] = '0;
            state_d[r] = blocked ? ST_COLLIDE : ST_IDLE;
          end else begin
            dwell_d[r] = dwell_q[r] + DWW'(1);
          end
        end
        ST_COLLIDE: begin
          if (press_q[r]) begin
            sel_d[r]   = step_sel(sel_q[r]);
            state_d[r] = ST_BREAK;
            dwell_d[r] = '0;
          end else if (sel_q[1-r] != sel_q[r]) begin
            state_d[r] = ST_BREAK;
            dwell_d[r] = '0;
          end
        end
        default: begin
          state_d[r] = ST_BREAK;
          dwell_d[r] = '0;
        end
      endcase
      relay_d[r] = (state_d[r] == ST_IDLE) ? one_hot(sel_d[r]) : '0;
      coll_d[r]  = (state_d[r] == ST_COLLIDE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      db_q    <= 2'b11;
      press_q <= 2'b00;
      coll_q  <= 2'b00;
      for (int r = 0; r < 2; r++) begin
        db_cnt_q[r] <= '0;
        state_q[r]  <= ST_BREAK;
        dwell_q[r]  <= '0;
        relay_q[r]  <= '0;
      end
      sel_q[0] <= 3'd0;
      sel_q[1] <= 3'd1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      press_q <= press_d;
      coll_q  <= coll_d;
      for (int r = 0; r < 2; r++) begin
        db_cnt_q[r] <= db_cnt_d[r];
        state_q[r]  <= state_d[r];
        dwell_q[r]  <= dwell_d[r];
        sel_q[r]    <= sel_d[r];
        relay_q[r]  <= relay_d[r];
      end
    end
  end

  assign sel_a       = sel_q[0];
  assign sel_b       = sel_q[1];
  assign collision_a = coll_q[0];
  assign collision_b = coll_q[1];
  assign relay_a     = relay_q[0];
  assign relay_b     = relay_q[1];

endmodule

// File: tb/tb_antenna_select_ctrl.sv
// tb/tb_antenna_select_ctrl.sv - directed bench for antenna_select_ctrl
module tb_antenna_select_ctrl;

  localparam int N_ANT = 6;
  localparam int DB    = 4;
  localparam int SD    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn_a_n = 1'b1;
  logic             btn_b_n = 1'b1;
  logic [2:0]       sel_a, sel_b;
  logic             collision_a, collision_b;
  logic [N_ANT-1:0] relay_a, relay_b;

  int n_tests = 0;
  int n_fail  = 0;

  antenna_select_ctrl #(
    .N_ANT(N_ANT), .DEBOUNCE_CYCLES(DB), .SWITCH_DELAY(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_a_n(btn_a_n), .btn_b_n(btn_b_n),
    .sel_a(sel_a), .sel_b(sel_b), .collision_a(collision_a), .collision_b(collision_b),
    .relay_a(relay_a), .relay_b(relay_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Continuous relay safety: mutual exclusion, no bit-to-bit change, dwell gap.
  logic [N_ANT-1:0] prev_a = '0, prev_b = '0;
  int zrun_a = 0, zrun_b = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a = '0; prev_b = '0; zrun_a = 0; zrun_b = 0;
    end else begin
      check_eq("excl", 32'(relay_a & relay_b), 32'd0);
      if (relay_a == '0) zrun_a++;
      else begin
        if (prev_a == '0) check_eq("gap_a", 32'(zrun_a >= SD), 32'd1);
        else check_eq("bbm_a", 32'(relay_a), 32'(prev_a));
        zrun_a = 0;
      end
      if (relay_b == '0) zrun_b++;
      else begin
        if (prev_b == '0) check_eq("gap_b", 32'(zrun_b >= SD), 32'd1);
        else check_eq("bbm_b", 32'(relay_b), 32'(prev_b));
        zrun_b = 0;
      end
      prev_a = relay_a;
      prev_b = relay_b;
    end
  end

  task automatic press(input logic a, input logic b, input int hold);
    @(posedge clk); #1;
    if (a) btn_a_n = 1'b0;
    if (b) btn_b_n = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    btn_a_n = 1'b1;
    btn_b_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic boot_check(input string tag);
    check_eq({tag, "_sel_a"}, 32'(sel_a), 32'd0);
    check_eq({tag, "_sel_b"}, 32'(sel_b), 32'd1);
    check_eq({tag, "_rly0"}, 32'({relay_a, relay_b}), 32'd0);
    for (int i = 1; i < SD; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_dwell"}, 32'({relay_a, relay_b}), 32'd0);
    end
    @(posedge clk); #1;
    check_eq({tag, "_relay_a"}, 32'(relay_a), 32'b000001);
    check_eq({tag, "_relay_b"}, 32'(relay_b), 32'b000010);
    check_eq({tag, "_coll"}, 32'({collision_a, collision_b}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic [2:0] seq_b [5];
    seq_b[0] = 3'd3; seq_b[1] = 3'd4; seq_b[2] = 3'd5; seq_b[3] = 3'd0; seq_b[4] = 3'd1;

    // 1: reset values and boot dwell
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_sel_b", 32'(sel_b), 32'd1);
    check_eq("rst_relays", 32'({relay_a, relay_b}), 32'd0);
    #1 rst_n = 1'b1;
    boot_check("s1");

    // 2: glitch ignored, long hold steps once, A collides with B
    press(1'b1, 1'b0, 3);
    check_eq("s2_glitch", 32'(sel_a), 32'd0);
    press(1'b1, 1'b0, 20);
    repeat (4) @(posedge clk);
    #1;
    check_eq("s2_sel_a", 32'(sel_a), 32'd1);
    check_eq("s2_coll_a", 32'(collision_a), 32'd1);
    check_eq("s2_relay_a", 32'(relay_a), 32'd0);
    check_eq("s2_relay_b", 32'(relay_b), 32'b000010);

    // 3: B moves away, A recovers
    press(1'b0, 1'b1, 6);
    check_eq("s3_sel_b", 32'(sel_b), 32'd2);
    check_eq("s3_relay_b0", 32'(relay_b), 32'd0);
    check_eq("s3_coll_a0", 32'(collision_a), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("s3_relay_a", 32'(relay_a), 32'b000010);
    check_eq("s3_relay_b", 32'(relay_b), 32'b000100);
    check_eq("s3_coll", 32'({collision_a, collision_b}), 32'd0);

    // 4: five B steps with wrap; lands on A's index and collides
    for (int i = 0; i < 5; i++) begin
      press(1'b0, 1'b1, 6);
      check_eq("s4_seq", 32'(sel_b), 32'(seq_b[i]));
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("s4_coll_b", 32'(collision_b), 32'd1);
    check_eq("s4_relay_b", 32'(relay_b), 32'd0);
    check_eq("s4_relay_a", 32'(relay_a), 32'b000010);

    // 5: both step to 3 together; A wins the tie
    press(1'b1, 1'b1, 6);
    check_eq("s5_sel1", 32'({sel_a, sel_b}), 32'({3'd2, 3'd2}));
    press(1'b1, 1'b1, 6);
    check_eq("s5_sel2", 32'({sel_a, sel_b}), 32'({3'd3, 3'd3}));
    repeat (3) @(posedge clk);
    #1;
    check_eq("s5_relay_a", 32'(relay_a), 32'b001000);
    check_eq("s5_relay_b", 32'(relay_b), 32'd0);
    check_eq("s5_coll_b", 32'(collision_b), 32'd1);
    check_eq("s5_coll_a", 32'(collision_a), 32'd0);

    // 6: reset mid-BREAK at dwell 5
    btn_a_n = 1'b0;
    k = 0;
    while (sel_a == 3'd3 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("s6_step", 32'(sel_a), 32'd4);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("s6_sel", 32'({sel_a, sel_b}), 32'({3'd0, 3'd1}));
    check_eq("s6_relays", 32'({relay_a, relay_b}), 32'd0);
    check_eq("s6_coll", 32'({collision_a, collision_b}), 32'd0);
    btn_a_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    boot_check("s6");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
